puf_response_collector: RTL and testbench

- Downstream consumer of the CT-PUF core. Drives its trigger input `T` and samples its single-bit `fnlout`.
- Majority-votes repeated evaluations into one stable bit, then packs RESP_W voted bits into a response word.
- Presents the word to the I/O/readout logic over a valid/ready handshake.
- Sits between the PUF core and the tile's output pins.

---
 rtl/puf_collect_pkg.sv | 10 +
 rtl/puf_sync2.sv | 12 +
 rtl/puf_response_collector.sv | 123 ++++++++++++
 tb/tb_puf_response_collector.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/puf_collect_pkg.sv
// puf_collect_pkg: collector FSM encoding, default sizing and counter-width helper
package puf_collect_pkg;
  typedef enum logic [2:0] {IDLE, TRIG, WAIT, SAMPLE, DECIDE, OUT} state_t;
  localparam int DEF_RESP_W = 8;
  localparam int DEF_VOTES  = 5;
  localparam int DEF_SETTLE = 4;
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/puf_sync2.sv
// puf_sync2: two-flop synchronizer for asynchronous PUF signals, resets to 0
module puf_sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic [1:0] sync_q, sync_d;
  always_comb sync_d = {sync_q[0], d};
  always_ff @(posedge clk) sync_q <= reset ? 2'b00 : sync_d;
  assign q = sync_q[1];
endmodule

// File: rtl/puf_response_collector.sv
// puf_response_collector: majority-votes PUF evaluations into a RESP_W word with valid/ready output.
// Optional PUF_STABILITY_FLAG_EN adds unstable_cnt, the number of non-unanimous voted bits.
module puf_response_collector
  import puf_collect_pkg::*;
#(
  parameter int RESP_W = DEF_RESP_W,
  parameter int VOTES  = DEF_VOTES,
  parameter int SETTLE = DEF_SETTLE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              puf_t,
  input  logic              puf_out,
  output logic [RESP_W-1:0] resp_data,
  output logic              resp_valid,
  input  logic              resp_ready,
`ifdef PUF_STABILITY_FLAG_EN
  output logic              busy,
  output logic [$clog2(RESP_W+1)-1:0] unstable_cnt
`else
  output logic              busy
`endif
);
  localparam int OW = cnt_w(VOTES + 1);
  localparam int VW = cnt_w(VOTES);
  localparam int BW = cnt_w(RESP_W);
  localparam int SW = cnt_w(SETTLE);
  if (VOTES % 2 == 0 || VOTES < 3 || VOTES > 15 || SETTLE < 2 || RESP_W < 2) begin : g_bad_cfg
    $error("puf_response_collector: VOTES must be odd 3..15, SETTLE>=2, RESP_W>=2");
  end
  state_t state_q, state_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [OW-1:0] ones_q, ones_d;
  logic [VW-1:0] vote_q, vote_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [RESP_W-1:0] shift_q, shift_d;
  logic puf_t_q, puf_t_d, valid_q, valid_d, busy_q, busy_d;
  logic puf_s, last_vote, last_bit;
  puf_sync2 u_sync (.clk(clk), .reset(reset), .d(puf_out), .q(puf_s));
  assign last_vote = vote_q == VW'(VOTES - 1);
  assign last_bit  = bit_q == BW'(RESP_W - 1);
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    ones_d   = ones_q;
    vote_d   = vote_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = TRIG;
        ones_d  = '0;
        vote_d  = '0;
        bit_d   = '0;
        shift_d = '0;
      end
      TRIG: begin
        state_d  = WAIT;
        settle_d = '0;
      end
      WAIT: begin
        settle_d = settle_q + 1'b1;
        state_d  = (settle_q == SW'(SETTLE - 1)) ? SAMPLE : WAIT;
      end
      SAMPLE: begin
        ones_d  = ones_q + OW'(puf_s);
        vote_d  = last_vote ? vote_q : vote_q + 1'b1;
        state_d = last_vote ? DECIDE : TRIG;
      end
      DECIDE: begin
        shift_d = {shift_q[RESP_W-2:0], ones_q > OW'(VOTES / 2)};
        ones_d  = '0;
        vote_d  = '0;
        bit_d   = last_bit ? bit_q : bit_q + 1'b1;
        state_d = last_bit ? OUT : TRIG;
      end
      OUT:     state_d = resp_ready ? IDLE : OUT;
      default: state_d = IDLE;
    endcase
    puf_t_d = state_d == TRIG;
    valid_d = state_d == OUT;
    busy_d  = state_d != IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      settle_q <= '0;
      ones_q   <= '0;
      vote_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      puf_t_q  <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      ones_q   <= ones_d;
      vote_q   <= vote_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      puf_t_q  <= puf_t_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
    end
  end
  assign puf_t      = puf_t_q;
  assign resp_data  = shift_q;
  assign resp_valid = valid_q;
  assign busy       = busy_q;
`ifdef PUF_STABILITY_FLAG_EN
  localparam int UW = $clog2(RESP_W + 1);
  logic [UW-1:0] unstable_q, unstable_d;
  always_comb begin
    unstable_d = unstable_q;
    if (state_q == IDLE && start) unstable_d = '0;
    if (state_q == DECIDE) unstable_d = unstable_q + UW'(ones_q != '0 && ones_q != OW'(VOTES));
  end
  always_ff @(posedge clk) unstable_q <= reset ? '0 : unstable_d;
  assign unstable_cnt = unstable_q;
`endif
endmodule

// File: tb/tb_puf_response_collector.sv
// tb_puf_response_collector: directed checks of voting, packing, handshake, pulse spacing and reset.
// Build with PUF_STABILITY_FLAG_EN defined to also check unstable_cnt.
module tb_puf_response_collector;
  localparam int RW = 8, V = 5, S = 4;
  localparam int LAT = 1 + RW * (V * (S + 2) + 1);
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, puf_out = 1'b0, resp_ready = 1'b0;
  logic puf_t, resp_valid, busy;
  logic [RW-1:0] resp_data;
`ifdef PUF_STABILITY_FLAG_EN
  logic [$clog2(RW+1)-1:0] unstable_cnt;
`endif
  int cyc = 0, n_cmp = 0, n_bad = 0;
  int rp = 0, tot = 0, hi = 0, lo = 0, mode = 0;
  bit first = 1'b1;
  logic [RW-1:0] word = '0;

  puf_response_collector #(.RESP_W(RW), .VOTES(V), .SETTLE(S)) dut (
    .clk(clk), .reset(reset), .start(start), .puf_t(puf_t), .puf_out(puf_out),
    .resp_data(resp_data), .resp_valid(resp_valid), .resp_ready(resp_ready),
`ifdef PUF_STABILITY_FLAG_EN
    .busy(busy), .unstable_cnt(unstable_cnt)
`else
    .busy(busy)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // mode 0: always 1; mode 1: word bit on every vote; mode 2: 3/5 ones for a 1, 2/5 for a 0
  function automatic logic pat(input int p);
    int b, v;
    logic bv;
    b = p / V;
    v = p % V;
    bv = (b < RW) ? word[RW-1-b] : 1'b0;
    if (mode == 0) return 1'b1;
    if (mode == 1) return bv;
    return v < (bv ? 3 : 2);
  endfunction

  always @(negedge clk) begin
    if (!busy) begin
      rp = 0;
      first = 1'b1;
    end
    if (puf_t) begin
      hi++;
      if (hi == 1) begin
        if (!first) check("pulse_gap", lo, (rp % V == 0) ? S + 2 : S + 1);
        first = 1'b0;
        puf_out = pat(rp);
        rp++;
        tot++;
      end
      lo = 0;
    end else begin
      if (hi != 0) check("pulse_width", hi, 1);
      hi = 0;
      lo++;
    end
  end

  task automatic run(input int m, input logic [RW-1:0] w, input bit rep);
    int s;
    mode = m;
    word = w;
    start = 1'b1;
    s = cyc;
    @(negedge clk);
    start = 1'b0;
    while (!resp_valid && cyc < s + LAT + 50) begin
      start = rep && (cyc == s + 40 || cyc == s + 110);
      @(negedge clk);
    end
    start = 1'b0;
    check("valid_rise", cyc, s + LAT);
    check("busy_in_out", busy, 1);
    check("pulse_count", rp, RW * V);
  endtask

  task automatic handshake();
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check("valid_drop", resp_valid, 0);
    check("idle_busy", busy, 0);
  endtask

  initial begin
    int s, t0;
    bit stable;
    repeat (3) @(negedge clk);
    check("rst_puf_t", puf_t, 0);
    check("rst_valid", resp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_data", resp_data, 0);
`ifdef PUF_STABILITY_FLAG_EN
    check("rst_unstable", unstable_cnt, 0);
`endif
    reset = 1'b0;
    while (cyc != 10) @(negedge clk);
    resp_ready = 1'b1;
    run(0, '0, 1'b0);
    check("ones_data", resp_data, 8'hFF);
`ifdef PUF_STABILITY_FLAG_EN
    check("ones_unstable", unstable_cnt, 0);
`endif
    @(negedge clk);
    resp_ready = 1'b0;
    check("early_ready_drop", resp_valid, 0);
    check("early_ready_idle", busy, 0);
    repeat (3) @(negedge clk);
    run(1, 8'hA6, 1'b0);
    check("a6_data", resp_data, 8'hA6);
    stable = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (resp_valid !== 1'b1 || resp_data !== 8'hA6) stable = 1'b0;
    end
    check("a6_hold", stable, 1);
    resp_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    start = 1'b0;
    check("a6_valid_drop", resp_valid, 0);
    check("a6_busy_drop", busy, 0);
    check("idle_data_hold", resp_data, 8'hA6);
    repeat (3) @(negedge clk);
    check("start_in_out_ignored", busy, 0);
    run(2, 8'h5A, 1'b0);
    check("maj_data", resp_data, 8'h5A);
`ifdef PUF_STABILITY_FLAG_EN
    check("maj_unstable", unstable_cnt, 8);
`endif
    handshake();
    repeat (2) @(negedge clk);
    run(1, 8'h3C, 1'b1);
    check("repulse_data", resp_data, 8'h3C);
    handshake();
    t0 = tot;
    repeat (10) @(negedge clk);
    check("repulse_no_restart", busy, 0);
    check("repulse_no_pulses", tot, t0);
    mode = 0;
    start = 1'b1;
    s = cyc;
    @(negedge clk);
    start = 1'b0;
    while (cyc < s + 90) @(negedge clk);
    check("mid_busy", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_puf_t", puf_t, 0);
    check("mid_rst_valid", resp_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_data", resp_data, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    run(1, 8'hC3, 1'b0);
    check("fresh_data", resp_data, 8'hC3);
`ifdef PUF_STABILITY_FLAG_EN
    check("fresh_unstable", unstable_cnt, 0);
`endif
    handshake();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end
endmodule
